// File: rtl/tns_encoder_pipe.sv
// -----------------------------------------------------------------------------
// tns_encoder_pipe
// Parametrised TNS-CAC encoder. Maps a DW-bit binary word onto NG three-wire
// groups (CW = 3*NG code bits) for a crosstalk-avoiding bus driver.
// Each group g holds three weights {A,B,C}. Groups are encoded from the MSB
// group (NG-1) down to group 0. A remainder starts at the input value and
// loses the weight of every bit that gets set. When the remainder falls in the
// ambiguous window [A, A+C), the a-bit repeats the a-bit last sent on that
// group (the transition memory).
//
// PIPELINED = 1 : one register stage per group, latency NG.
// PIPELINED = 0 : a single combinational chain and an output register, latency 1.
// Both builds give the same code sequence for the same input order.
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous, active-high reset
//   mem_clear  synchronous clear of every memory bit
//   in_valid   input word valid
//   in_ready   encoder can take a word this cycle
//   in_data    binary value to encode
//   out_valid  out_code / out_err valid
//   out_ready  downstream accepts the output
//   out_code   code word; bits [3g+2:3g] are {a,b,c} of group g
//   out_err    input was larger than the sum of all weights
// -----------------------------------------------------------------------------
module tns_encoder_pipe #(
   parameter int NG = 4,
   parameter int DW = 11,
   parameter int WW = 12,
   parameter logic [3*NG*WW-1:0] WEIGHTS = {
      12'd1029, 12'd686, 12'd343,
      12'd147,  12'd98,  12'd49,
      12'd21,   12'd14,  12'd7,
      12'd3,    12'd2,   12'd1
   },
   parameter bit PIPELINED = 1'b1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            mem_clear,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [DW-1:0]   in_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [3*NG-1:0] out_code,
   output logic            out_err
);

   localparam int CW = 3*NG;

   typedef struct packed {
      logic [2:0]    bits;
      logic [WW-1:0] rem;
   } grpRes_t;

   // slot 2 = A, slot 1 = B, slot 0 = C of group g
   function automatic logic [WW-1:0] weightOf(input int g, input int slot);
      return WEIGHTS[(3*g+slot)*WW +: WW];
   endfunction

   function automatic int sumWeights();
      int s;
      s = 0;
      for (int i = 0; i < 3*NG; i++) begin
         s += int'(WEIGHTS[i*WW +: WW]);
      end
      return s;
   endfunction

   localparam int MAXVAL_I = sumWeights();
   localparam logic [WW:0] MAXVAL = MAXVAL_I[WW:0];

   // Encodes one group. The weights guarantee the remainder never underflows.
   // In group 0, C is 1, so the c-bit is simply the remaining LSB.
   function automatic grpRes_t encGroup(input logic [WW-1:0] remIn,
                                        input logic memBit, input int g);
      grpRes_t res;
      logic [WW-1:0] wA, wB, wC, r;
      logic a, b, c;
      wA = weightOf(g, 2);
      wB = weightOf(g, 1);
      wC = weightOf(g, 0);
      r  = remIn;
      if (r < wA) begin
         a = 1'b0;
      end else if (r >= wA + wC) begin
         a = 1'b1;
      end else begin
         a = memBit;
      end
      if (a) begin
         r = r - wA;
      end
      b = (r >= wB);
      if (b) begin
         r = r - wB;
      end
      if (g == 0) begin
         c = r[0];
      end else begin
         c = (r >= wC);
      end
      if (c) begin
         r = r - wC;
      end
      res.bits = {a, b, c};
      res.rem  = r;
      return res;
   endfunction

   // An out-of-range word still travels down the pipe, but with a zero
   // remainder. Its code is forced to zero and it never touches the memory.
   logic          inErr;
   logic [WW-1:0] inRem;

   assign inErr = ({{(WW+1-DW){1'b0}}, in_data} > MAXVAL);
   assign inRem = inErr ? '0 : {{(WW-DW){1'b0}}, in_data};

   if (PIPELINED) begin : gPipe
      logic [NG-1:0] validQ;
      logic [NG-1:0] errQ;
      logic [NG-1:0] memQ;
      logic [WW-1:0] remQ  [NG];
      logic [CW-1:0] codeQ [NG];
      logic [NG-1:0] stageInValid;
      logic [NG-1:0] stageInErr;
      logic [NG-1:0] stageReady;
      logic [NG-1:0] stageLoad;
      logic [WW-1:0] stageInRem  [NG];
      logic [CW-1:0] stageInCode [NG];
      logic [CW-1:0] codeD       [NG];
      grpRes_t       stageRes    [NG];

      // Stage k handles group NG-1-k. Ready ripples back from the output:
      // a stage can load if it is empty or if its word moves on this cycle,
      // so a full pipe with out_ready high never inserts a bubble.
      always_comb begin
         stageInValid = '0;
         stageInErr   = '0;
         stageReady   = '0;
         stageLoad    = '0;
         stageInRem   = '{default: '0};
         stageInCode  = '{default: '0};
         codeD        = '{default: '0};
         stageRes     = '{default: '0};

         stageReady[NG-1] = ~validQ[NG-1] | out_ready;
         for (int k = NG-2; k >= 0; k--) begin
            stageReady[k] = ~validQ[k] | stageReady[k+1];
         end

         stageInValid[0] = in_valid;
         stageInErr[0]   = inErr;
         stageInRem[0]   = inRem;
         stageInCode[0]  = '0;
         for (int k = 1; k < NG; k++) begin
            stageInValid[k] = validQ[k-1];
            stageInErr[k]   = errQ[k-1];
            stageInRem[k]   = remQ[k-1];
            stageInCode[k]  = codeQ[k-1];
         end

         for (int k = 0; k < NG; k++) begin
            stageRes[k]  = encGroup(stageInRem[k], memQ[NG-1-k], NG-1-k);
            stageLoad[k] = stageInValid[k] & stageReady[k];
            codeD[k]     = stageInErr[k] ? '0 :
                           (stageInCode[k] | (CW'(stageRes[k].bits) << (3*(NG-1-k))));
         end
      end

      // Stage registers plus per-group memory. Each memory bit is written
      // only when its own stage loads a word, so words update the memory in
      // input order, exactly as in the combinational build. mem_clear
      // overrides that write.
      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            validQ <= '0;
            errQ   <= '0;
            memQ   <= '0;
            for (int k = 0; k < NG; k++) begin
               remQ[k]  <= '0;
               codeQ[k] <= '0;
            end
         end else begin
            for (int k = 0; k < NG; k++) begin
               if (stageReady[k]) begin
                  validQ[k] <= stageInValid[k];
               end
               if (stageLoad[k]) begin
                  remQ[k]  <= stageRes[k].rem;
                  codeQ[k] <= codeD[k];
                  errQ[k]  <= stageInErr[k];
               end
            end
            if (mem_clear) begin
               memQ <= '0;
            end else begin
               for (int k = 0; k < NG; k++) begin
                  if (stageLoad[k] && !stageInErr[k]) begin
                     memQ[NG-1-k] <= stageRes[k].bits[2];
                  end
               end
            end
         end
      end

      assign in_ready  = stageReady[0];
      assign out_valid = validQ[NG-1];
      assign out_code  = codeQ[NG-1];
      assign out_err   = errQ[NG-1];
   end else begin : gComb
      logic          outValidQ;
      logic          outErrQ;
      logic [CW-1:0] outCodeQ;
      logic [CW-1:0] codeD;
      logic [NG-1:0] memQ;
      logic [NG-1:0] aBits;
      logic          outFree;
      logic          accept;

      // Whole group chain in one cycle, MSB group first.
      always_comb begin
         logic [WW-1:0] r;
         grpRes_t       res;
         r     = inRem;
         res   = '0;
         codeD = '0;
         aBits = '0;
         for (int g = NG-1; g >= 0; g--) begin
            res             = encGroup(r, memQ[g], g);
            codeD[3*g +: 3] = res.bits;
            aBits[g]        = res.bits[2];
            r               = res.rem;
         end
         if (inErr) begin
            codeD = '0;
         end
      end

      assign outFree = ~outValidQ | out_ready;
      assign accept  = in_valid & outFree;

      // Output register holds its word while it is stalled. The memory
      // takes the new a-bits of each accepted in-range word unless a
      // clear arrives in the same cycle.
      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            outValidQ <= 1'b0;
            outErrQ   <= 1'b0;
            outCodeQ  <= '0;
            memQ      <= '0;
         end else begin
            if (outFree) begin
               outValidQ <= in_valid;
               if (in_valid) begin
                  outCodeQ <= codeD;
                  outErrQ  <= inErr;
               end
            end
            if (mem_clear) begin
               memQ <= '0;
            end else if (accept && !inErr) begin
               memQ <= aBits;
            end
         end
      end

      assign in_ready  = outFree;
      assign out_valid = outValidQ;
      assign out_code  = outCodeQ;
      assign out_err   = outErrQ;
   end

endmodule

// File: tb/tb_tns_encoder_pipe.sv
// -----------------------------------------------------------------------------
// tb_tns_encoder_pipe
// Exercises three builds of tns_encoder_pipe:
//   sel 0 : default weights, pipelined
//   sel 1 : default weights, combinational
//   sel 2 : NG=1, weights {2,1,1}, combinational
// Only the selected build sees in_valid. Its outputs are muxed onto the
// observation signals. Expected codes come from an integer model of the
// encoding rules, which keeps its own per-group memory.
// -----------------------------------------------------------------------------
module tb_tns_encoder_pipe;

   logic        clock = 1'b0;
   logic        reset;
   logic        memClear;
   logic        inValid;
   logic        outReady;
   logic [10:0] inData;
   int          sel;

   logic        readyP, validP, errP;
   logic        readyC, validC, errC;
   logic        readyS, validS, errS;
   logic [11:0] codeP, codeC;
   logic [2:0]  codeS;

   logic        inReadyObs, outValidObs, outErrObs;
   logic [11:0] outCodeObs;

   always #5 clock = ~clock;

   tns_encoder_pipe #(.PIPELINED(1'b1)) dutP (
      .clock(clock), .reset(reset), .mem_clear(memClear),
      .in_valid(inValid & (sel == 0)), .in_ready(readyP), .in_data(inData),
      .out_valid(validP), .out_ready(outReady), .out_code(codeP), .out_err(errP)
   );

   tns_encoder_pipe #(.PIPELINED(1'b0)) dutC (
      .clock(clock), .reset(reset), .mem_clear(memClear),
      .in_valid(inValid & (sel == 1)), .in_ready(readyC), .in_data(inData),
      .out_valid(validC), .out_ready(outReady), .out_code(codeC), .out_err(errC)
   );

   tns_encoder_pipe #(.NG(1), .DW(3), .WW(12),
                      .WEIGHTS({12'd2, 12'd1, 12'd1}), .PIPELINED(1'b0)) dutS (
      .clock(clock), .reset(reset), .mem_clear(memClear),
      .in_valid(inValid & (sel == 2)), .in_ready(readyS), .in_data(inData[2:0]),
      .out_valid(validS), .out_ready(outReady), .out_code(codeS), .out_err(errS)
   );

   assign inReadyObs  = (sel == 0) ? readyP : (sel == 1) ? readyC : readyS;
   assign outValidObs = (sel == 0) ? validP : (sel == 1) ? validC : validS;
   assign outErrObs   = (sel == 0) ? errP   : (sel == 1) ? errC   : errS;
   assign outCodeObs  = (sel == 0) ? codeP  : (sel == 1) ? codeC  : {9'b0, codeS};

   int testCount = 0;
   int failCount = 0;

   // Every comparison goes through here.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Reference model state for the selected configuration.
   int mNg;
   int maxVal;
   int wA[4];
   int wB[4];
   int wC[4];
   int mMem[4];

   typedef struct {
      logic [11:0] code;
      logic        err;
      int          data;
   } expEntry_t;

   expEntry_t sbQ[$];
   bit        useModel;
   bit        lastAccept;

   task automatic setConfig(input int s);
      sel = s;
      if (s == 2) begin
         mNg = 1;
         wA[0] = 2; wB[0] = 1; wC[0] = 1;
      end else begin
         mNg = 4;
         wA[3] = 1029; wB[3] = 686; wC[3] = 343;
         wA[2] = 147;  wB[2] = 98;  wC[2] = 49;
         wA[1] = 21;   wB[1] = 14;  wC[1] = 7;
         wA[0] = 3;    wB[0] = 2;   wC[0] = 1;
      end
      maxVal = 0;
      for (int g = 0; g < mNg; g++) begin
         maxVal += wA[g] + wB[g] + wC[g];
      end
   endtask

   // Integer version of the encoding rules. It updates the model memory
   // for in-range words.
   function automatic void modelEncode(input int v, output logic [11:0] code,
                                       output logic err);
      int r, a, b, c;
      code = '0;
      err  = (v > maxVal);
      if (!err) begin
         r = v;
         for (int g = mNg-1; g >= 0; g--) begin
            if (r < wA[g]) a = 0;
            else if (r >= wA[g] + wC[g]) a = 1;
            else a = mMem[g];
            r = r - a*wA[g];
            b = (r >= wB[g]) ? 1 : 0;
            r = r - b*wB[g];
            c = (g == 0) ? r : ((r >= wC[g]) ? 1 : 0);
            r = r - c*wC[g];
            code[3*g+2] = (a != 0);
            code[3*g+1] = (b != 0);
            code[3*g]   = (c != 0);
            mMem[g] = a;
         end
      end
   endfunction

   // Sum of the weights whose code bits are set.
   function automatic int decodeCode(input logic [11:0] code);
      int s;
      s = 0;
      for (int g = 0; g < mNg; g++) begin
         if (code[3*g+2]) s += wA[g];
         if (code[3*g+1]) s += wB[g];
         if (code[3*g])   s += wC[g];
      end
      return s;
   endfunction

   // Drives one clock cycle from a falling edge. With useModel set it also
   // checks the output against the head of the scoreboard and pushes the
   // model result of an accepted word.
   task automatic applyStimulus(input bit v, input int d, input bit rdy, input bit clr);
      logic [11:0] c;
      logic        e;
      inValid  = v;
      inData   = d[10:0];
      outReady = rdy;
      memClear = clr;
      #1;
      lastAccept = v & inReadyObs;
      if (useModel) begin
         if (outValidObs) begin
            if (sbQ.size() == 0) begin
               checkOutput("spurious_valid", 32'(outValidObs), 32'd0);
            end else begin
               checkOutput("code", 32'(outCodeObs), 32'(sbQ[0].code));
               checkOutput("err", 32'(outErrObs), 32'(sbQ[0].err));
               if (rdy) begin
                  if (!sbQ[0].err) begin
                     checkOutput("decode", 32'(decodeCode(outCodeObs)), 32'(sbQ[0].data));
                  end
                  void'(sbQ.pop_front());
               end
            end
         end
         if (lastAccept) begin
            modelEncode(d, c, e);
            sbQ.push_back('{c, e, d});
         end
      end
      if (clr) begin
         for (int g = 0; g < 4; g++) mMem[g] = 0;
      end
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic applyReset();
      reset    = 1'b1;
      inValid  = 1'b0;
      memClear = 1'b0;
      outReady = 1'b0;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      sbQ.delete();
      for (int g = 0; g < 4; g++) mMem[g] = 0;
   endtask

   // Sends one word with out_ready high. Checks the accept, the latency
   // to out_valid and the resulting code against constants.
   task automatic sendWord(input string tag, input int data, input bit clr,
                           input logic [11:0] expCode, input bit expErr, input int expLat);
      int w;
      int lat;
      w = 0;
      do begin
         applyStimulus(1'b1, data, 1'b1, clr);
         w++;
      end while (!lastAccept && w < 20);
      checkOutput({tag, "_accept"}, 32'(lastAccept), 32'd1);
      lat = 1;
      while (!outValidObs && lat < 20) begin
         applyStimulus(1'b0, 0, 1'b1, 1'b0);
         lat++;
      end
      checkOutput({tag, "_lat"}, 32'(lat), 32'(expLat));
      checkOutput({tag, "_code"}, 32'(outCodeObs), 32'(expCode));
      checkOutput({tag, "_err"}, 32'(outErrObs), 32'(expErr));
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sbQ.size() > 0 && n < 200) begin
         applyStimulus(1'b0, 0, 1'b1, 1'b0);
         n++;
      end
      checkOutput("drain_left", 32'(sbQ.size()), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int bubbles;
      bit sawLow;

      reset = 1'b1; memClear = 1'b0; inValid = 1'b0; outReady = 1'b0;
      inData = '0; useModel = 1'b0; lastAccept = 1'b0;
      setConfig(0);
      @(negedge clock);

      // Reset values of every build
      applyReset();
      for (int s = 0; s < 3; s++) begin
         setConfig(s);
         #1;
         checkOutput("rst_valid", 32'(outValidObs), 32'd0);
         checkOutput("rst_ready", 32'(inReadyObs), 32'd1);
         checkOutput("rst_err", 32'(outErrObs), 32'd0);
         checkOutput("rst_code", 32'(outCodeObs), 32'd0);
      end

      // Small config, directed
      setConfig(2);
      applyReset();
      sendWord("s_in1", 1, 1'b0, 12'b010, 1'b0, 1);
      sendWord("s_in3", 3, 1'b0, 12'b110, 1'b0, 1);
      applyReset();
      sendWord("s_seq0", 0, 1'b0, 12'b000, 1'b0, 1);
      sendWord("s_seq2", 2, 1'b0, 12'b011, 1'b0, 1);
      applyReset();
      sendWord("s_m3", 3, 1'b0, 12'b110, 1'b0, 1);
      sendWord("s_m2", 2, 1'b0, 12'b100, 1'b0, 1);
      applyStimulus(1'b0, 0, 1'b1, 1'b1);
      sendWord("s_clr2", 2, 1'b0, 12'b011, 1'b0, 1);
      applyReset();
      sendWord("s_oor_pre", 3, 1'b0, 12'b110, 1'b0, 1);
      sendWord("s_oor", 5, 1'b0, 12'b000, 1'b1, 1);
      sendWord("s_after_oor", 2, 1'b0, 12'b100, 1'b0, 1);
      applyReset();
      sendWord("s_cs_pre", 3, 1'b0, 12'b110, 1'b0, 1);
      sendWord("s_clr_same", 2, 1'b1, 12'b100, 1'b0, 1);
      sendWord("s_post_clr", 2, 1'b0, 12'b011, 1'b0, 1);

      // Small config, reset while words are in flight
      applyReset();
      sendWord("s_rr_pre", 3, 1'b0, 12'b110, 1'b0, 1);
      applyStimulus(1'b0, 0, 1'b1, 1'b0);
      applyStimulus(1'b1, 2, 1'b0, 1'b0);
      applyStimulus(1'b1, 1, 1'b0, 1'b0);
      reset = 1'b1;
      #1;
      checkOutput("s_rst_mid_valid", 32'(outValidObs), 32'd0);
      applyReset();
      sendWord("s_rst_next", 2, 1'b0, 12'b011, 1'b0, 1);

      // Default weights, directed latency and code
      setConfig(0);
      applyReset();
      sendWord("p_2047", 2047, 1'b0, 12'hDF3, 1'b0, 4);
      sendWord("p_zero", 0, 1'b0, 12'h000, 1'b0, 4);
      setConfig(1);
      applyReset();
      sendWord("c_2047", 2047, 1'b0, 12'hDF3, 1'b0, 1);

      // Pipelined build against the model
      setConfig(0);
      applyReset();
      useModel = 1'b1;
      bubbles = 0;
      for (int i = 0; i < 2048; i++) begin
         applyStimulus(1'b1, i, 1'b1, 1'b0);
         if (!lastAccept) bubbles++;
      end
      checkOutput("stream_bubbles", 32'(bubbles), 32'd0);
      drain();

      for (int i = 0; i < 20; i++) applyStimulus(1'b1, int'($urandom_range(0, 2047)), 1'b1, 1'b0);
      sawLow = 1'b0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, int'($urandom_range(0, 2047)), 1'b0, 1'b0);
         if (!lastAccept) sawLow = 1'b1;
      end
      checkOutput("bp_in_ready_drop", 32'(sawLow), 32'd1);
      for (int i = 0; i < 20; i++) applyStimulus(1'b1, int'($urandom_range(0, 2047)), 1'b1, 1'b0);
      drain();

      for (int i = 0; i < 3; i++) applyStimulus(1'b1, int'($urandom_range(0, 2047)), 1'b0, 1'b0);
      reset = 1'b1;
      #1;
      checkOutput("p_rst_mid_valid", 32'(outValidObs), 32'd0);
      applyReset();

      for (int i = 0; i < 1500; i++) begin
         applyStimulus($urandom_range(0, 3) != 0, int'($urandom_range(0, 2047)),
                       $urandom_range(0, 9) < 3, 1'b0);
      end
      drain();
      applyStimulus(1'b0, 0, 1'b1, 1'b1);
      for (int i = 0; i < 300; i++) begin
         applyStimulus($urandom_range(0, 1) != 0, int'($urandom_range(0, 2047)),
                       $urandom_range(0, 1) != 0, 1'b0);
      end
      drain();

      // Combinational build with random clears
      setConfig(1);
      applyReset();
      for (int i = 0; i < 1500; i++) begin
         applyStimulus($urandom_range(0, 3) != 0, int'($urandom_range(0, 2047)),
                       $urandom_range(0, 9) < 5, $urandom_range(0, 19) == 0);
      end
      drain();

      // Small config, random values including out-of-range
      setConfig(2);
      applyReset();
      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
                       $urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0);
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
